// File: rtl/soc_onchip_mem_pkg.sv
// Shared constants and helpers for the dual-port on-chip scratch memory.
package soc_onchip_mem_pkg;

  localparam int unsigned MAX_READ_LATENCY = 2;

  // Collision priority: 1 lets s1 own any byte lane both ports write to one address.
  localparam bit PRIO_S1 = 1'b1;

  function automatic int unsigned be_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/soc_onchip_mem_rdpipe.sv
// Read-return delay line: valid and data move together through LATENCY enabled stages.
module soc_onchip_mem_rdpipe
  import soc_onchip_mem_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  if (LATENCY < 1 || LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $error("soc_onchip_mem_rdpipe: LATENCY must be 1 or 2");
  end

  logic [LATENCY-1:0] v_q;
  logic [DATA_W-1:0]  d_q [LATENCY];

  // Index 0 is the stage input, index LATENCY is the last register.
  logic [LATENCY:0]   v_all;
  logic [DATA_W-1:0]  d_all [LATENCY+1];

  always_comb begin
    v_all    = {v_q, in_valid};
    d_all[0] = in_data;
    for (int i = 0; i < int'(LATENCY); i++) begin
      d_all[i+1] = d_q[i];
    end
  end

  // Data only advances with a valid, so the last stage holds its value between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        d_q[i] <= '0;
      end
    end else if (en) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        v_q[i] <= v_all[i];
        if (v_all[i]) begin
          d_q[i] <= d_all[i];
        end
      end
    end
  end

  // A stalled cycle never shows a valid; the pending one is shown on the next enabled cycle.
  assign valid = v_all[LATENCY] & en;
  assign data  = d_all[LATENCY];

endmodule

// File: rtl/soc_onchip_memory_dp.sv
// True dual-port Avalon-MM scratch RAM shared by the CPU (s1) and renderer DMA (s2).
module soc_onchip_memory_dp
  import soc_onchip_mem_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned READ_LATENCY = 1,
  parameter string       INIT_FILE    = "soc_onchip_memory_dp.hex"
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      reset_req,
  input  logic                      clken,
  input  logic [ADDR_W-1:0]         s1_address,
  input  logic                      s1_chipselect,
  input  logic                      s1_read,
  input  logic                      s1_write,
  input  logic [be_w(DATA_W)-1:0]   s1_byteenable,
  input  logic [DATA_W-1:0]         s1_writedata,
  output logic [DATA_W-1:0]         s1_readdata,
  output logic                      s1_readdatavalid,
  input  logic [ADDR_W-1:0]         s2_address,
  input  logic                      s2_chipselect,
  input  logic                      s2_read,
  input  logic                      s2_write,
  input  logic [be_w(DATA_W)-1:0]   s2_byteenable,
  input  logic [DATA_W-1:0]         s2_writedata,
  output logic [DATA_W-1:0]         s2_readdata,
  output logic                      s2_readdatavalid
);

  localparam int unsigned BE_W  = be_w(DATA_W);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  if (DATA_W == 0 || DATA_W % 8 != 0) begin : g_bad_width
    $error("soc_onchip_memory_dp: DATA_W must be a non-zero multiple of 8");
  end

  // The array has no reset; its power-up image is loaded from INIT_FILE by the implementation flow.
  if (INIT_FILE == "") begin : g_no_init
    $error("soc_onchip_memory_dp: INIT_FILE must name a power-up image");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic            en;
  logic            wr1, wr2, rd1, rd2, hit;
  logic [BE_W-1:0] lane1, lane2;

  assign en  = clken & ~reset_req;
  assign wr1 = s1_chipselect & s1_write & en;
  assign wr2 = s2_chipselect & s2_write & en;
  assign rd1 = s1_chipselect & s1_read & ~s1_write & en;
  assign rd2 = s2_chipselect & s2_read & ~s2_write & en;
  assign hit = (s1_address == s2_address);

  // Per-lane merge: on a same-address collision only the priority port writes the shared lanes.
  always_comb begin
    lane1 = '0;
    lane2 = '0;
    for (int b = 0; b < int'(BE_W); b++) begin
      lane1[b] = wr1 & s1_byteenable[b] & ~(~PRIO_S1 & hit & wr2 & s2_byteenable[b]);
      lane2[b] = wr2 & s2_byteenable[b] & ~( PRIO_S1 & hit & wr1 & s1_byteenable[b]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (lane1[b]) mem[s1_address][b*8 +: 8] <= s1_writedata[b*8 +: 8];
        if (lane2[b]) mem[s2_address][b*8 +: 8] <= s2_writedata[b*8 +: 8];
      end
    end
  end

  // Stage 1 of each pipe registers the array word, so a mixed-port read sees pre-write data.
  soc_onchip_mem_rdpipe #(
    .DATA_W  (DATA_W),
    .LATENCY (READ_LATENCY)
  ) u_rdpipe_s1 (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .in_valid (rd1),
    .in_data  (mem[s1_address]),
    .valid    (s1_readdatavalid),
    .data     (s1_readdata)
  );

  soc_onchip_mem_rdpipe #(
    .DATA_W  (DATA_W),
    .LATENCY (READ_LATENCY)
  ) u_rdpipe_s2 (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .in_valid (rd2),
    .in_data  (mem[s2_address]),
    .valid    (s2_readdatavalid),
    .data     (s2_readdata)
  );

endmodule

// File: tb/tb_soc_onchip_memory_dp.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based memory model.
module tb_soc_onchip_memory_dp;

  localparam int LAT = 2;

  logic        clk;
  logic        rst, reset_req, clken;
  logic [9:0]  addr  [2];
  logic        cs    [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [3:0]  be    [2];
  logic [31:0] wd    [2];
  logic [31:0] rdata [2];
  logic        rvalid[2];

  soc_onchip_memory_dp #(
    .DATA_W(32), .ADDR_W(10), .READ_LATENCY(LAT), .INIT_FILE("soc_onchip_memory_dp.hex")
  ) dut (
    .clk(clk), .reset(rst), .reset_req(reset_req), .clken(clken),
    .s1_address(addr[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
    .s1_byteenable(be[0]), .s1_writedata(wd[0]), .s1_readdata(rdata[0]),
    .s1_readdatavalid(rvalid[0]),
    .s2_address(addr[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
    .s2_byteenable(be[1]), .s2_writedata(wd[1]), .s2_readdata(rdata[1]),
    .s2_readdatavalid(rvalid[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Behavioural model: word array, per-port list of outstanding reads with enabled-edge age.
  typedef struct {
    logic [31:0] data;
    int          age;
  } ent_t;

  logic [31:0] mm [1024];
  ent_t        pend [2][$];
  logic [31:0] rd_exp [2];
  logic [31:0] rec [2][$];
  int          rec_cyc [2][$];
  int          cyc = 0;
  bit          checking = 0;

  function automatic bit due(input int p);
    ent_t h;
    if (pend[p].size() == 0) return 1'b0;
    h = pend[p][0];
    return h.age == LAT;
  endfunction

  always @(posedge clk) begin
    ent_t e;
    cyc++;
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        pend[p].delete();
        rd_exp[p] = '0;
      end
    end else if (clken && !reset_req) begin
      for (int p = 0; p < 2; p++) begin
        if (due(p)) void'(pend[p].pop_front());
        for (int i = 0; i < pend[p].size(); i++) begin
          e = pend[p][i];
          e.age++;
          pend[p][i] = e;
        end
        if (cs[p] && rd[p] && !wr[p]) begin
          e.data = mm[addr[p]];
          e.age  = 1;
          pend[p].push_back(e);
        end
        if (due(p)) begin
          e = pend[p][0];
          rd_exp[p] = e.data;
        end
      end
      // s2 first, then s1, so s1 owns lanes both ports hit
      for (int p = 1; p >= 0; p--) begin
        if (cs[p] && wr[p]) begin
          for (int b = 0; b < 4; b++) begin
            if (be[p][b]) mm[addr[p]][b*8 +: 8] = wd[p][b*8 +: 8];
          end
        end
      end
    end
  end

  // Output compare, on the falling edge
  always @(negedge clk) begin
    if (checking && !rst) begin
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("valid s%0d cyc %0d", p + 1, cyc), 32'(rvalid[p]),
            32'(clken && !reset_req && due(p)));
        chk($sformatf("readdata s%0d cyc %0d", p + 1, cyc), rdata[p], rd_exp[p]);
        if (rvalid[p] === 1'b1) begin
          rec[p].push_back(rdata[p]);
          rec_cyc[p].push_back(cyc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input bit r, input bit w, input logic [9:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    cs[p] = r | w; rd[p] = r; wr[p] = w; addr[p] = a; be[p] = b; wd[p] = d;
  endtask

  task automatic idle();
    for (int p = 0; p < 2; p++) drive(p, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic clear_rec();
    for (int p = 0; p < 2; p++) begin
      rec[p].delete();
      rec_cyc[p].delete();
    end
  endtask

  // Reads one address on both ports at once and pins the returned word.
  task automatic rd_both(input logic [9:0] a, input logic [31:0] exp, input string name);
    clear_rec();
    drive(0, 1'b1, 1'b0, a, '0, '0);
    drive(1, 1'b1, 1'b0, a, '0, '0);
    step(1);
    idle();
    step(LAT + 2);
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("%s s%0d count", name, p + 1), 32'(rec[p].size()), 32'd1);
      if (rec[p].size() > 0) chk($sformatf("%s s%0d data", name, p + 1), rec[p][0], exp);
    end
  endtask

  function automatic logic [9:0] win(input int i);
    return (i < 8) ? 10'(i) : 10'(1016 + i - 8);
  endfunction

  initial begin
    int acc;
    rst = 1'b1; reset_req = 1'b0; clken = 1'b1;
    idle();
    for (int i = 0; i < 1024; i++) mm[i] = '0;
    step(3);
    rst = 1'b0;
    checking = 1;
    chk("reset s1 valid", 32'(rvalid[0]), 32'd0);
    chk("reset s2 valid", 32'(rvalid[1]), 32'd0);
    chk("reset s1 data", rdata[0], 32'h0);
    chk("reset s2 data", rdata[1], 32'h0);

    // Full write then read, with latency pinned
    drive(0, 1'b0, 1'b1, 10'h005, 4'hF, 32'hDEADBEEF);
    step(1);
    idle();
    drive(0, 1'b1, 1'b0, 10'h005, '0, '0);
    step(1);
    acc = cyc;
    idle();
    clear_rec();
    step(LAT + 2);
    chk("t1 count", 32'(rec[0].size()), 32'd1);
    if (rec[0].size() > 0) begin
      chk("t1 data", rec[0][0], 32'hDEADBEEF);
      chk("t1 latency", 32'(rec_cyc[0][0]), 32'(acc + LAT - 1));
    end

    // Byte lanes
    drive(0, 1'b0, 1'b1, 10'h005, 4'b0101, 32'h11223344);
    step(1);
    idle();
    rd_both(10'h005, 32'hDE22BE44, "lanes");

    // Same-address write collision
    drive(0, 1'b0, 1'b1, 10'h010, 4'b0011, 32'hAAAAAAAA);
    drive(1, 1'b0, 1'b1, 10'h010, 4'b1111, 32'h55555555);
    step(1);
    idle();
    chk("model collision", mm[16], 32'h5555AAAA);
    rd_both(10'h010, 32'h5555AAAA, "collision");

    // Mixed-port read during write returns old data
    clear_rec();
    drive(1, 1'b1, 1'b0, 10'h005, '0, '0);
    drive(0, 1'b0, 1'b1, 10'h005, 4'hF, 32'h0);
    step(1);
    idle();
    step(LAT + 2);
    chk("rdw s2 count", 32'(rec[1].size()), 32'd1);
    if (rec[1].size() > 0) chk("rdw s2 old", rec[1][0], 32'hDE22BE44);
    chk("rdw s1 count", 32'(rec[0].size()), 32'd0);
    rd_both(10'h005, 32'h0, "rdw new");

    // Stall between back-to-back reads
    drive(0, 1'b0, 1'b1, 10'h007, 4'hF, 32'hCAFEF00D);
    step(1);
    clear_rec();
    drive(0, 1'b1, 1'b0, 10'h005, '0, '0);
    step(1);
    drive(0, 1'b1, 1'b0, 10'h010, '0, '0);
    step(1);
    drive(0, 1'b1, 1'b0, 10'h007, '0, '0);
    clken = 1'b0;
    step(2);
    clken = 1'b1;
    step(1);
    idle();
    step(LAT + 3);
    chk("stall count", 32'(rec[0].size()), 32'd3);
    if (rec[0].size() == 3) begin
      chk("stall d0", rec[0][0], 32'h0);
      chk("stall d1", rec[0][1], 32'h5555AAAA);
      chk("stall d2", rec[0][2], 32'hCAFEF00D);
    end

    // Reset while a read is in flight
    clear_rec();
    drive(0, 1'b1, 1'b0, 10'h007, '0, '0);
    step(1);
    idle();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(LAT + 2);
    chk("rst flight count", 32'(rec[0].size()), 32'd0);
    chk("rst flight data", rdata[0], 32'h0);
    rd_both(10'h007, 32'hCAFEF00D, "after rst");

    // Randomized traffic over a small address window at both ends of the range
    for (int i = 0; i < 8; i++) begin
      drive(0, 1'b0, 1'b1, win(i), 4'hF, $urandom);
      drive(1, 1'b0, 1'b1, win(i + 8), 4'hF, $urandom);
      step(1);
    end
    for (int n = 0; n < 3000; n++) begin
      clken     = ($urandom_range(0, 9) != 0);
      reset_req = ($urandom_range(0, 9) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      for (int p = 0; p < 2; p++) begin
        int op;
        op = int'($urandom_range(0, 3));
        drive(p, op[0], op[1], win(int'($urandom_range(0, 15))), 4'($urandom), $urandom);
        if ($urandom_range(0, 7) == 0) cs[p] = 1'b0;
      end
      step(1);
    end
    idle();
    rst = 1'b0; clken = 1'b1; reset_req = 1'b0;
    step(LAT + 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/soc_onchip_memory_dp.md
Name: soc_onchip_memory_dp

Overview:
- Parametrised true-dual-port Avalon-MM on-chip RAM: next generation of the single-port 4-word SoC scratch memory.
- Two independent slaves (s1, s2) share one storage array.
- Adds width/depth parameters, selectable read latency, an explicit readdatavalid, and defined collision and read-during-write rules.
- Sits on the SoC interconnect as shared scratch/descriptor memory between the CPU (s1) and the renderer DMA (s2).

Parameters:
- DATA_W, 32, word width in bits; multiple of 8.
- ADDR_W, 10, word address width; depth = 2**ADDR_W.
- READ_LATENCY, 1, cycles from read accept to readdatavalid; legal values 1 or 2 (2 adds an output register).
- INIT_FILE, "soc_onchip_memory_dp.hex", power-up contents; simulation and synthesis init only.

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- reset_req  in  1  pending-reset request; gates clock enable
- clken  in  1  global clock enable
- s1_address  in  ADDR_W  port 1 word address
- s1_chipselect  in  1  port 1 select
- s1_read  in  1  port 1 read request
- s1_write  in  1  port 1 write request
- s1_byteenable  in  DATA_W/8  port 1 byte lanes
- s1_writedata  in  DATA_W  port 1 write data
- s1_readdata  out  DATA_W  port 1 read data
- s1_readdatavalid  out  1  port 1 read data qualifier
- s2_*  same set, same widths, for port 2

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset. No waitrequest; every request is accepted in its cycle when en=1.
- en = clken & ~reset_req. When en=0: no write commits, no read is accepted, the read pipeline holds, and readdatavalid is 0.
- Write: chipselect & write & en commits the enabled byte lanes at the clock edge. Disabled lanes are unchanged.
- Read: chipselect & read & ~write & en accepts a read. If read and write are both high, the access is a write only and produces no readdatavalid.
- Read data path: the array output is registered (stage 1). For READ_LATENCY=2, a second register follows (stage 2).
- readdatavalid: pulses high for exactly one en=1 cycle, READ_LATENCY enabled cycles after accept. The valid bit travels with the data.
- readdata holds its last value between valids. Back-to-back reads give one valid per cycle, in order.
- Stalls: en low mid-flight freezes data and valid stages. Delivery resumes on the next en=1 cycle; no loss, no duplication.
- Read-during-write, same port: impossible by the read/write rule above.
- Read-during-write, mixed port (s2 reads the address s1 writes in the same cycle, or vice versa): returns OLD data.
- Write collision, same address and same cycle: per byte lane, s1 wins where both byteenables are set. s2 lanes not enabled on s1 are written from s2.
- Reset:
  - clears all valid stages; readdatavalid=0 and readdata=0 on both ports from the cycle after reset is sampled;
  - memory contents are NOT cleared;
  - in-flight reads are dropped; writes in a reset cycle are ignored.
- reset_req: blocks new accesses only; it does not flush the pipeline.
- Address: full range, no wrap logic needed. Width mismatches are not permitted (parameter check, DATA_W%8==0, elaboration error otherwise).

Decomposition:
- Package soc_onchip_mem_pkg holds:
  - function be_w(DATA_W) = DATA_W/8;
  - constant MAX_READ_LATENCY = 2;
  - collision-priority localparam PRIO_S1 = 1.
- Sub-module soc_onchip_mem_rdpipe: valid+data delay line of READ_LATENCY stages with enable and sync reset. Instantiated once per port.
- Storage is an inferred dual-port array, with byte-lane write loop and explicit s1-over-s2 lane merge for collisions.

Test Plan:
- Reset, then s1 write 0xDEADBEEF @0x005 with be=1111; s1 read @0x005 -> readdatavalid exactly 1 cycle later (LAT=1) or 2 cycles later (LAT=2), readdata=0xDEADBEEF.
- Byte lanes: write 0x11223344 with be=0101 over 0xDEADBEEF -> read returns 0xDE22BE44 on both s1 and s2.
- Collision: same cycle, s1 writes 0xAAAAAAAA be=0011 and s2 writes 0x55555555 be=1111 @0x010 -> memory word = 0x5555AAAA.
- Mixed read-during-write: s2 reads @0x005 while s1 writes 0x0 there -> s2 gets the old value 0xDE22BE44; next read returns 0x0.
- Stall: 3 back-to-back s1 reads with clken dropped for 2 cycles after the 2nd accept -> exactly 3 valids, in order; none while clken=0.
- Reset mid-flight: reset asserted the cycle after a read accept (LAT=2) -> no readdatavalid; readdata=0; memory still holds prior data on a later read.
